// File: rtl/warp_scheduler_gto.sv
// Per-cycle warp selector: loose round-robin or greedy-then-oldest, with an age-based
// starvation override, behind a registered valid/ready issue port.
module warp_scheduler_gto #(
   parameter int unsigned WARPS        = 8,
   parameter int unsigned IDW          = 3,
   parameter int unsigned AGEW         = 4,
   parameter int unsigned STARVE_LIMIT = 12
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WARPS-1:0] ready_mask,
   input  logic             policy,
   input  logic             issue_ready,
   output logic             issue_valid,
   output logic [IDW-1:0]   issue_idx,
   output logic [WARPS-1:0] issue_onehot,
   output logic             starve_flag
);

   localparam logic [AGEW-1:0]  LIMIT   = AGEW'(STARVE_LIMIT);
   localparam logic [AGEW-1:0]  AGE_MAX = '1;
   localparam logic [WARPS-1:0] ONE     = WARPS'(1);

   logic [AGEW-1:0] age [WARPS];
   logic [IDW-1:0]  last_idx;
   logic            last_vld;

   logic            accept;
   logic            load;
   logic            any_ready;
   logic [IDW-1:0]  eff_last;
   logic            eff_vld;

   logic            starve_hit;
   logic [IDW-1:0]  starve_idx;
   logic            best_hit;
   logic [IDW-1:0]  best_idx;
   logic [AGEW-1:0] best_age;
   logic            rr_hit;
   logic [IDW-1:0]  rr_idx;
   logic [IDW-1:0]  scan_idx;
   logic [IDW-1:0]  cand_idx;
   logic            cand_starve;

   assign accept    = issue_valid & issue_ready;
   assign load      = ~issue_valid | issue_ready;
   assign any_ready = |ready_mask;

   // A warp accepted this cycle counts as the most recent issue for the
   // selection that loads in the same cycle, so LRR advances and GTO stays greedy.
   assign eff_last = accept ? issue_idx : last_idx;
   assign eff_vld  = accept | last_vld;

   always_comb begin
      starve_hit = 1'b0;
      starve_idx = '0;
      best_hit   = 1'b0;
      best_idx   = '0;
      best_age   = '0;
      for (int unsigned i = 0; i < WARPS; i++) begin
         if (!starve_hit && ready_mask[IDW'(i)] && (age[IDW'(i)] >= LIMIT)) begin
            starve_hit = 1'b1;
            starve_idx = IDW'(i);
         end
         if (ready_mask[IDW'(i)] && (!best_hit || (age[IDW'(i)] > best_age))) begin
            best_hit = 1'b1;
            best_idx = IDW'(i);
            best_age = age[IDW'(i)];
         end
      end
   end

   always_comb begin
      rr_hit   = 1'b0;
      rr_idx   = '0;
      scan_idx = '0;
      for (int unsigned k = 1; k <= WARPS; k++) begin
         scan_idx = IDW'((32'(eff_last) + k) % WARPS);
         if (!rr_hit && ready_mask[scan_idx]) begin
            rr_hit = 1'b1;
            rr_idx = scan_idx;
         end
      end
   end

   always_comb begin
      cand_idx    = '0;
      cand_starve = 1'b0;
      if (starve_hit) begin
         cand_idx    = starve_idx;
         cand_starve = 1'b1;
      end else if (policy) begin
         if (eff_vld && ready_mask[eff_last]) cand_idx = eff_last;
         else                                 cand_idx = best_idx;
      end else begin
         cand_idx = rr_idx;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         issue_valid  <= 1'b0;
         issue_idx    <= '0;
         issue_onehot <= '0;
         starve_flag  <= 1'b0;
         last_idx     <= IDW'(WARPS - 1);
         last_vld     <= 1'b0;
         for (int unsigned i = 0; i < WARPS; i++) age[i] <= '0;
      end else begin
         if (accept) begin
            last_idx <= issue_idx;
            last_vld <= 1'b1;
         end
         if (load) begin
            issue_valid  <= any_ready;
            issue_idx    <= any_ready ? cand_idx : '0;
            issue_onehot <= any_ready ? (ONE << cand_idx) : '0;
            starve_flag  <= any_ready & cand_starve;
         end
         for (int unsigned i = 0; i < WARPS; i++) begin
            if (accept && (issue_idx == IDW'(i)))
               age[i] <= '0;
            else if (ready_mask[IDW'(i)] && (age[i] != AGE_MAX))
               age[i] <= age[i] + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_warp_scheduler_gto.sv
// Directed bench for warp_scheduler_gto: reset, LRR order and wrap, GTO greed,
// stall hold, starvation override, empty mask and reset during a stall.
module tb_warp_scheduler_gto;

   localparam int unsigned WARPS = 8;
   localparam int unsigned IDW   = 3;

   logic             clk = 1'b0;
   logic             rst;
   logic [WARPS-1:0] ready_mask;
   logic             policy;
   logic             issue_ready;
   logic             issue_valid;
   logic [IDW-1:0]   issue_idx;
   logic [WARPS-1:0] issue_onehot;
   logic             starve_flag;

   int unsigned pass_cnt  = 0;
   int unsigned check_cnt = 0;

   warp_scheduler_gto #(
      .WARPS(WARPS),
      .IDW(IDW),
      .AGEW(4),
      .STARVE_LIMIT(12)
   ) dut (
      .clk(clk),
      .rst(rst),
      .ready_mask(ready_mask),
      .policy(policy),
      .issue_ready(issue_ready),
      .issue_valid(issue_valid),
      .issue_idx(issue_idx),
      .issue_onehot(issue_onehot),
      .starve_flag(starve_flag)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      check_cnt++;
      if (obs === exp) pass_cnt++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic expect_issue(input string tag, input int unsigned idx, input logic stv);
      logic [WARPS-1:0] oh;
      oh = '0;
      oh[idx] = 1'b1;
      check({tag, ".valid"},  32'(issue_valid),  32'd1);
      check({tag, ".idx"},    32'(issue_idx),    32'(idx));
      check({tag, ".onehot"}, 32'(issue_onehot), 32'(oh));
      check({tag, ".starve"}, 32'(starve_flag),  32'(stv));
   endtask

   task automatic expect_idle(input string tag);
      check({tag, ".valid"},  32'(issue_valid),  32'd0);
      check({tag, ".idx"},    32'(issue_idx),    32'd0);
      check({tag, ".onehot"}, 32'(issue_onehot), 32'd0);
      check({tag, ".starve"}, 32'(starve_flag),  32'd0);
   endtask

   task automatic do_reset(input logic [WARPS-1:0] mask);
      rst        = 1'b1;
      ready_mask = mask;
      tick();
      tick();
      rst = 1'b0;
   endtask

   initial begin
      rst         = 1'b1;
      ready_mask  = '0;
      policy      = 1'b0;
      issue_ready = 1'b0;

      // Reset state and LRR rotation through all warps with wrap back to 0
      do_reset(8'hFF);
      expect_idle("reset");
      ready_mask  = 8'hFF;
      policy      = 1'b0;
      issue_ready = 1'b1;
      for (int unsigned n = 0; n < 9; n++) begin
         tick();
         expect_issue($sformatf("lrr_seq%0d", n), n % WARPS, 1'b0);
      end
      ready_mask = 8'h00;
      tick();
      expect_idle("empty_mask");

      // GTO: warp 0 stays greedy, then lowest-index tie among equal ages
      do_reset(8'h00);
      policy      = 1'b1;
      ready_mask  = 8'hFF;
      issue_ready = 1'b1;
      for (int unsigned n = 0; n < 5; n++) begin
         tick();
         expect_issue($sformatf("gto_greedy%0d", n), 0, 1'b0);
      end
      ready_mask = 8'hFE;
      tick();
      expect_issue("gto_tiebreak", 1, 1'b0);
      tick();
      expect_issue("gto_regreedy", 1, 1'b0);

      // Stall: held warp is frozen even though its ready bit drops
      do_reset(8'h00);
      policy      = 1'b0;
      ready_mask  = 8'h08;
      issue_ready = 1'b0;
      tick();
      expect_issue("stall_first", 3, 1'b0);
      ready_mask = 8'h10;
      for (int unsigned n = 0; n < 5; n++) begin
         tick();
         expect_issue($sformatf("stall_hold%0d", n), 3, 1'b0);
      end
      issue_ready = 1'b1;
      tick();
      expect_issue("stall_release", 4, 1'b0);

      // Starvation override: warp 1 forced in once its age reaches the limit
      do_reset(8'h00);
      policy      = 1'b1;
      ready_mask  = 8'h03;
      issue_ready = 1'b1;
      for (int unsigned n = 0; n < 12; n++) begin
         tick();
         expect_issue($sformatf("starve_w0_%0d", n), 0, 1'b0);
      end
      tick();
      expect_issue("starve_force", 1, 1'b1);
      ready_mask = 8'h01;
      tick();
      expect_issue("starve_resume", 0, 1'b0);

      // LRR wrap: after warp 6, scan 7 then 0, then on to 5
      do_reset(8'h00);
      policy      = 1'b0;
      ready_mask  = 8'h40;
      issue_ready = 1'b1;
      tick();
      expect_issue("wrap_w6", 6, 1'b0);
      ready_mask = 8'h21;
      tick();
      expect_issue("wrap_w0", 0, 1'b0);
      tick();
      expect_issue("wrap_w5", 5, 1'b0);
      tick();
      expect_issue("wrap_w0b", 0, 1'b0);

      // Reset in the middle of a stalled handshake drops the held warp
      do_reset(8'h00);
      policy      = 1'b0;
      ready_mask  = 8'h04;
      issue_ready = 1'b0;
      tick();
      expect_issue("rststall_held", 2, 1'b0);
      tick();
      expect_issue("rststall_hold2", 2, 1'b0);
      rst = 1'b1;
      tick();
      expect_idle("rststall_cleared");
      rst = 1'b0;
      tick();
      expect_issue("rststall_after", 2, 1'b0);

      $display("%0d/%0d checks passed", pass_cnt, check_cnt);
      $finish;
   end

endmodule
